// File: rtl/cpu_bus_bridge_if.sv
// ---------------------------------------------------------------------------
// cpu_bus_bridge_if
//
// Groups the CPU-side and system-bus-side signals of cpu_bus_bridge.
//
// Handshake (one comment for the whole block):
//   * A bus cycle is launched on the clock edge where the bridge registers
//     ab/dbo/we; cyc is high for exactly the following clk to mark it.
//   * While the access is in progress the slave holds ext_ready low to
//     stretch it; ext_ready is only looked at once the region wait-state
//     count has drained, so it is a "ready" in the valid/ready sense with
//     the launched cycle acting as the standing "valid".
//   * The cycle completes on the first edge where the wait count is zero
//     and ext_ready is high. dbi is captured into cpu_di on that edge and
//     cpu_rdy is high for exactly the following clk, so the CPU sees
//     cpu_di and cpu_rdy together.
//
// Parameters: AW address width, DW data width.
// Modports:
//   master - the bridge: takes CPU request + slave response, drives
//            registered bus outputs and the CPU read data / advance pulse.
//   slave  - the environment (CPU core + memory/peripheral bus).
// ---------------------------------------------------------------------------
interface cpu_bus_bridge_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  // CPU side
  logic [AW-1:0] cpu_ab;
  logic [DW-1:0] cpu_do;
  logic          cpu_we;
  logic [DW-1:0] cpu_di;
  logic          cpu_rdy;
  // System bus side
  logic [AW-1:0] ab;
  logic [DW-1:0] dbo;
  logic          we;
  logic [DW-1:0] dbi;
  logic          cyc;
  logic          ext_ready;

  modport master (
    input  cpu_ab, cpu_do, cpu_we, dbi, ext_ready,
    output cpu_di, cpu_rdy, ab, dbo, we, cyc
  );

  modport slave (
    output cpu_ab, cpu_do, cpu_we, dbi, ext_ready,
    input  cpu_di, cpu_rdy, ab, dbo, we, cyc
  );
endinterface

// File: rtl/cpu_bus_bridge.sv
// ---------------------------------------------------------------------------
// cpu_bus_bridge
//
// Bridge between a 6502-class CPU core and the system memory/peripheral
// bus. A free-running divider produces the CPU tick; on a tick the bridge
// launches a bus cycle with registered address/data/write strobe, adds
// wait states for a slow address region, honours the slave ready, and on
// completion returns read data with a one-clk cpu_rdy advance pulse.
// A debug single-step mode parks the bridge in HALT after every cycle.
//
// Parameters:
//   AW, DW        address / data width
//   CLK_DIV       clk cycles per CPU tick (>= 1)
//   WAIT_MASK     mask applied to cpu_ab for slow-region decode
//   WAIT_BASE     slow-region match value
//   WAIT_CYCLES   extra wait clocks for slow-region accesses (0..255)
//   COUNT_INIT    reset value of cycle_count (0 in normal builds; a value
//                 near the top lets a build exercise the counter wrap)
//
// Ports:
//   clk, reset    system clock, asynchronous active-high reset
//   bus           cpu_bus_bridge_if.master (CPU + system bus signals)
//   step_en       single-step mode enable
//   step_req      single-step request, rising-edge sensitive
//   halted        bridge parked in HALT
//   cycle_count   completed bus cycles, wraps modulo 2^32
//   state_dbg     current FSM state (0 RUN, 1 ACCESS, 2 HALT)
// ---------------------------------------------------------------------------
module cpu_bus_bridge #(
  parameter int            AW          = 16,
  parameter int            DW          = 8,
  parameter int            CLK_DIV     = 2,
  parameter logic [AW-1:0] WAIT_MASK   = 16'hF000,
  parameter logic [AW-1:0] WAIT_BASE   = 16'hD000,
  parameter int            WAIT_CYCLES = 3,
  parameter logic [31:0]   COUNT_INIT  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  cpu_bus_bridge_if.master  bus,
  input  logic              step_en,
  input  logic              step_req,
  output logic              halted,
  output logic [31:0]       cycle_count,
  output logic [1:0]        state_dbg
);

  // -------------------------------------------------------------------------
  // Tick divider: counts 0..CLK_DIV-1 forever and never stalls, so the CPU
  // tick cadence is independent of how long bus cycles take.
  // -------------------------------------------------------------------------
  localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [7:0]     WAIT_INIT = 8'(WAIT_CYCLES);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [7:0] wcnt;
  logic       step_req_q;
  logic       step_rise;
  logic       launch;
  logic       complete;
  logic       slow_hit;

  // Edge detect against last clk's step_req. The history register runs in
  // every state, so an edge seen outside HALT is consumed and not queued.
  assign step_rise = step_req & ~step_req_q;
  assign slow_hit  = ((bus.cpu_ab & WAIT_MASK) == WAIT_BASE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    launch   = 1'b0;
    complete = 1'b0;
    case (state)
      ST_RUN: begin
        if (tick) begin
          launch  = 1'b1;
          state_n = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Slave ready only matters once the region wait states are spent.
        if ((wcnt == 8'd0) && bus.ext_ready) begin
          complete = 1'b1;
          state_n  = step_en ? ST_HALT : ST_RUN;
        end
      end
      ST_HALT: begin
        // Dropping step_en releases the bridge as well as a step request.
        if (step_rise || !step_en) begin
          state_n = ST_RUN;
        end
      end
      default: begin
        state_n = ST_RUN;
      end
    endcase
  end

  assign halted    = (state == ST_HALT);
  assign state_dbg = state;

  // -------------------------------------------------------------------------
  // Registered datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_req_q  <= 1'b0;
      wcnt        <= 8'd0;
      bus.ab      <= '0;
      bus.dbo     <= '0;
      bus.we      <= 1'b0;
      bus.cyc     <= 1'b0;
      bus.cpu_rdy <= 1'b0;
      bus.cpu_di  <= '0;
      cycle_count <= COUNT_INIT;
    end else begin
      step_req_q  <= step_req;
      bus.cyc     <= launch;
      bus.cpu_rdy <= complete;

      if (launch) begin
        bus.ab  <= bus.cpu_ab;
        bus.dbo <= bus.cpu_do;
        bus.we  <= bus.cpu_we;
        wcnt    <= slow_hit ? WAIT_INIT : 8'd0;
      end else if ((state == ST_ACCESS) && (wcnt != 8'd0)) begin
        wcnt <= wcnt - 8'd1;
      end

      // Completion ends the write strobe; we stays low through HALT/RUN
      // until the next launch reloads it.
      if (complete) begin
        bus.cpu_di  <= bus.dbi;
        bus.we      <= 1'b0;
        cycle_count <= cycle_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_bridge.sv
module tb_cpu_bus_bridge;

  localparam int D = 2;           // CLK_DIV of the main instance
  localparam int SLOW_WAIT = 3;   // WAIT_CYCLES of all instances

  // ------------------------------------------------------------------
  // Clock / reset
  // ------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  logic reset2;
  always #5 clk = ~clk;

  // Number of posedges since reset was released (edge k of the spec).
  int edge_n;
  always @(posedge clk or posedge reset) begin
    if (reset) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  // ------------------------------------------------------------------
  // DUTs: main build (CLK_DIV=2) plus CLK_DIV=1 (preloaded counter) and
  // CLK_DIV=5 builds.
  // ------------------------------------------------------------------
  cpu_bus_bridge_if #(.AW(16), .DW(8)) bi ();
  cpu_bus_bridge_if #(.AW(16), .DW(8)) bi1 ();
  cpu_bus_bridge_if #(.AW(16), .DW(8)) bi5 ();

  logic        step_en, step_req, halted;
  logic [31:0] cycle_count;
  logic [1:0]  state_dbg;
  logic        halted1, halted5;
  logic [31:0] cnt1, cnt5;
  logic [1:0]  st1, st5;

  cpu_bus_bridge #(.CLK_DIV(D)) dut (
    .clk(clk), .reset(reset), .bus(bi), .step_en(step_en), .step_req(step_req),
    .halted(halted), .cycle_count(cycle_count), .state_dbg(state_dbg)
  );

  cpu_bus_bridge #(.CLK_DIV(1), .COUNT_INIT(32'hFFFF_FFFD)) dut1 (
    .clk(clk), .reset(reset2), .bus(bi1), .step_en(1'b0), .step_req(1'b0),
    .halted(halted1), .cycle_count(cnt1), .state_dbg(st1)
  );

  cpu_bus_bridge #(.CLK_DIV(5)) dut5 (
    .clk(clk), .reset(reset2), .bus(bi5), .step_en(1'b0), .step_req(1'b0),
    .halted(halted5), .cycle_count(cnt5), .state_dbg(st5)
  );

  // ------------------------------------------------------------------
  // Scoreboard state and reference model
  // ------------------------------------------------------------------
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_count;
  logic [7:0]  exp_di;
  int          last_done;   // edge after which the bridge is back in RUN

  // First tick edge strictly after edge 'after' (divider ticks on edges
  // k with (k-1) mod D == D-1).
  function automatic int next_tick(input int after);
    int e;
    e = after + 1;
    while (((e - 1) % D) != (D - 1)) e++;
    return e;
  endfunction

  function automatic int region_wait(input logic [15:0] a);
    return ((a & 16'hF000) == 16'hD000) ? SLOW_WAIT : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus transaction on the main DUT. Called at a negedge where the
  // bridge is (or is about to be) in RUN from edge start_e+1 on.
  // stall: clocks of ext_ready low after the wait states.
  // rnd: drive a fresh random dbi every clk, else hold dv.
  // poke: pulse step_req during the access (must be ignored).
  task automatic do_txn(input logic [15:0] a, input logic [7:0] d, input logic w,
                        input int stall, input int start_e, input bit rnd,
                        input logic [7:0] dv, input bit poke);
    int waitc, n, launch_e, exp_done;
    logic [7:0] dbi_cur;
    bit seen;
    waitc = region_wait(a);
    bi.cpu_ab = a; bi.cpu_do = d; bi.cpu_we = w;
    bi.ext_ready = 1'($urandom_range(0, 1));
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      check("rdy_once", 32'(bi.cpu_rdy), 32'd0);
      check("di_hold", 32'(bi.cpu_di), 32'(exp_di));
      if (bi.cyc) seen = 1;
      else bi.dbi = rnd ? 8'($urandom) : dv;
    end
    check("launch_seen", 32'(seen), 32'd1);
    if (!seen) return;
    launch_e = edge_n;
    check("launch_edge", 32'(launch_e), 32'(next_tick(start_e)));
    check("ab", 32'(bi.ab), 32'(a));
    check("dbo", 32'(bi.dbo), 32'(d));
    check("we_launch", 32'(bi.we), 32'(w));
    check("halted_run", 32'(halted), 32'd0);

    exp_done = launch_e + waitc + stall + 1;
    n = 0;
    bi.ext_ready = (waitc + stall == 0);
    dbi_cur = rnd ? 8'($urandom) : dv;
    bi.dbi = dbi_cur;
    if (poke) step_req = 1'b1;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (poke) step_req = 1'b0;
      if (bi.cpu_rdy) begin
        seen = 1;
      end else begin
        check("we_hold", 32'(bi.we), 32'(w));
        check("cyc_once", 32'(bi.cyc), 32'd0);
        dbi_cur = rnd ? 8'($urandom) : dv;
        bi.dbi = dbi_cur;
        bi.ext_ready = (n >= waitc + stall);
      end
    end
    check("rdy_seen", 32'(seen), 32'd1);
    if (!seen) return;
    exp_count = exp_count + 32'd1;
    exp_di = dbi_cur;
    check("done_edge", 32'(edge_n), 32'(exp_done));
    check("cpu_di", 32'(bi.cpu_di), 32'(exp_di));
    check("we_clear", 32'(bi.we), 32'd0);
    check("count", cycle_count, exp_count);
    check("ab_hold", 32'(bi.ab), 32'(a));
    last_done = edge_n;
  endtask

  // Bridge must sit in HALT without launching for n clks.
  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++) begin
      check("halted", 32'(halted), 32'd1);
      check("no_cyc", 32'(bi.cyc), 32'd0);
      check("halt_we", 32'(bi.we), 32'd0);
      @(negedge clk);
    end
  endtask

  // ------------------------------------------------------------------
  // Directed/random sequence
  // ------------------------------------------------------------------
  initial begin
    int e;
    logic [15:0] a;
    bit seen;
    reset = 1'b1; reset2 = 1'b1;
    step_en = 1'b0; step_req = 1'b0;
    bi.cpu_ab = 16'h0300; bi.cpu_do = 8'h00; bi.cpu_we = 1'b0;
    bi.dbi = 8'h5A; bi.ext_ready = 1'b1;
    bi1.cpu_ab = 16'h0300; bi1.cpu_do = 8'h00; bi1.cpu_we = 1'b0;
    bi1.dbi = 8'h33; bi1.ext_ready = 1'b1;
    bi5.cpu_ab = 16'h0310; bi5.cpu_do = 8'h00; bi5.cpu_we = 1'b0;
    bi5.dbi = 8'hC4; bi5.ext_ready = 1'b1;
    exp_count = 32'd0; exp_di = 8'h00; last_done = 0;

    repeat (3) @(negedge clk);
    check("rst_ab", 32'(bi.ab), 32'd0);
    check("rst_dbo", 32'(bi.dbo), 32'd0);
    check("rst_we", 32'(bi.we), 32'd0);
    check("rst_cyc", 32'(bi.cyc), 32'd0);
    check("rst_rdy", 32'(bi.cpu_rdy), 32'd0);
    check("rst_di", 32'(bi.cpu_di), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_count", cycle_count, 32'd0);
    reset = 1'b0;

    // Fast-region reads of 0300 returning 5A.
    for (int i = 0; i < 3; i++)
      do_txn(16'h0300, 8'h00, 1'b0, 0, last_done, 1'b0, 8'h5A, 1'b0);
    // Slow-region write.
    do_txn(16'hD012, 8'h8D, 1'b1, 0, last_done, 1'b0, 8'h00, 1'b0);
    do_txn(16'h0300, 8'h00, 1'b0, 0, last_done, 1'b0, 8'h5A, 1'b0);
    // Fast read stretched 5 clks by the slave.
    do_txn(16'h1234, 8'h00, 1'b0, 5, last_done, 1'b1, 8'h00, 1'b0);
    // Slow read stretched after the wait states.
    do_txn(16'hD0FF, 8'h00, 1'b0, 2, last_done, 1'b1, 8'h00, 1'b0);

    // Random traffic.
    for (int i = 0; i < 25; i++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 1) == 1) a = {4'hD, a[11:0]};
      do_txn(a, 8'($urandom), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 4)), last_done, 1'b1, 8'h00, 1'b0);
    end

    // Single-step: one cycle then HALT; a step_req edge during the access
    // must not be remembered.
    step_en = 1'b1;
    do_txn(16'hD200, 8'h11, 1'b1, 0, last_done, 1'b1, 8'h00, 1'b1);
    halt_hold(6);
    // One pulse gives exactly one cycle.
    step_req = 1'b1; e = edge_n + 1;
    @(negedge clk); step_req = 1'b0;
    do_txn(16'h0400, 8'h00, 1'b0, 1, e, 1'b1, 8'h00, 1'b0);
    halt_hold(6);
    // Held high: one cycle, then stays halted.
    step_req = 1'b1; e = edge_n + 1;
    do_txn(16'hD401, 8'h22, 1'b1, 0, e, 1'b1, 8'h00, 1'b0);
    halt_hold(10);
    step_req = 1'b0;
    halt_hold(2);
    // Leaving step mode resumes normal running.
    step_en = 1'b0; e = edge_n + 1;
    do_txn(16'h0500, 8'h00, 1'b0, 0, e, 1'b1, 8'h00, 1'b0);
    do_txn(16'h0501, 8'h00, 1'b0, 0, last_done, 1'b1, 8'h00, 1'b0);

    // Reset during wait clk 2 of a slow write.
    bi.cpu_ab = 16'hD123; bi.cpu_do = 8'h77; bi.cpu_we = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bi.cyc) seen = 1;
    end
    check("mid_launch", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    check("mid_we_before", 32'(bi.we), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_we", 32'(bi.we), 32'd0);
    check("mid_cyc", 32'(bi.cyc), 32'd0);
    check("mid_rdy", 32'(bi.cpu_rdy), 32'd0);
    check("mid_ab", 32'(bi.ab), 32'd0);
    check("mid_dbo", 32'(bi.dbo), 32'd0);
    check("mid_count", cycle_count, 32'd0);
    check("mid_di", 32'(bi.cpu_di), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_count = 32'd0; exp_di = 8'h00; last_done = 0;
    do_txn(16'h0300, 8'h00, 1'b0, 0, 0, 1'b0, 8'h5A, 1'b0);
    do_txn(16'hD055, 8'h9C, 1'b1, 1, last_done, 1'b1, 8'h00, 1'b0);

    // CLK_DIV=1 and CLK_DIV=5 builds: periods, first launch, counter wrap.
    begin
      int prev1, prev5, n1, n5;
      logic [31:0] c1, c5;
      prev1 = -1; prev5 = -1; n1 = 0; n5 = 0;
      c1 = 32'hFFFF_FFFD; c5 = 32'd0;
      reset2 = 1'b0;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (bi1.cyc) begin
          if (prev1 < 0) check("d1_first", 32'(k), 32'd1);
          else           check("d1_period", 32'(k - prev1), 32'd2);
          prev1 = k; n1++;
        end
        if (bi1.cpu_rdy) begin
          c1 = c1 + 32'd1;
          check("d1_count", cnt1, c1);
          check("d1_di", 32'(bi1.cpu_di), 32'h33);
        end
        if (bi5.cyc) begin
          if (prev5 < 0) check("d5_first", 32'(k), 32'd5);
          else           check("d5_period", 32'(k - prev5), 32'd5);
          prev5 = k; n5++;
        end
        if (bi5.cpu_rdy) begin
          c5 = c5 + 32'd1;
          check("d5_count", cnt5, c5);
          check("d5_di", 32'(bi5.cpu_di), 32'hC4);
        end
      end
      // Launches at 1,3,..,39 and 5,10,..,40.
      check("d1_launches", 32'(n1), 32'd20);
      check("d5_launches", 32'(n5), 32'd8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_bus_bridge.md
# cpu_bus_bridge

Parametrised bus bridge between a 6502-class CPU core and the system memory/peripheral bus. It is the next generation of the registered CPU bus wrapper. It generates the CPU's one-clock advance strobe from an internal clock divider, registers the address, write-data and write-enable outputs, inserts wait states for a configurable slow address region, honours a slave ready handshake, and supports debug single-stepping with a completed-cycle counter.

## Interface
- AW, 16, address width
- DW, 8, data width
- CLK_DIV, 2, clk cycles per CPU tick (≥1)
- WAIT_MASK, 16'hF000, AW-bit mask applied to the address for slow-region decode
- WAIT_BASE, 16'hD000, AW-bit slow-region match value
- WAIT_CYCLES, 3, extra wait clocks for slow-region accesses (0–255)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_ab  in  AW  CPU address (combinational from core)
- cpu_do  in  DW  CPU write data
- cpu_we  in  1  CPU write enable
- cpu_di  out  DW  registered read data to CPU
- cpu_rdy  out  1  one-clk advance pulse to CPU RDY
- ab  out  AW  registered bus address
- dbo  out  DW  registered bus write data
- we  out  1  registered bus write strobe
- dbi  in  DW  bus read data
- cyc  out  1  one-clk pulse marking bus-cycle launch
- ext_ready  in  1  slave ready; low stretches the access
- step_en  in  1  single-step mode enable
- step_req  in  1  single-step request, rising-edge sensitive
- halted  out  1  bridge parked in HALT
- cycle_count  out  32  completed bus cycles, wraps

## Operation
- Divider: div_cnt counts 0..CLK_DIV-1 continuously. tick = (div_cnt == CLK_DIV-1). The divider never stalls.
- Reset values: ab=0, dbo=0, we=0, cyc=0, cpu_rdy=0, cpu_di=0, halted=0, cycle_count=0, div_cnt=0, state=RUN, wcnt=0, step_req history=0.
- States:
  - RUN, on tick:
    - latch ab←cpu_ab, dbo←cpu_do, we←cpu_we; pulse cyc.
    - wcnt←WAIT_CYCLES if (cpu_ab & WAIT_MASK)==WAIT_BASE, else 0.
    - go to ACCESS.
  - RUN, not on tick: hold.
  - ACCESS, each clk:
    - if wcnt≠0: decrement wcnt.
    - else if ext_ready: complete the cycle.
    - else: hold (unbounded).
  - Completion:
    - cpu_di←dbi; we←0; cpu_rdy=1 for exactly this clk; cycle_count+1 (mod 2^32).
    - next state HALT if step_en, else RUN.
  - HALT:
    - halted=1; bus outputs hold except we=0.
    - a rising edge of step_req (registered history) moves to RUN.
    - step_en falling also moves to RUN.
- ab and dbo hold their values between launches. cpu_di holds until the next completion.
- ext_ready is sampled only when wcnt==0 in ACCESS.
- A step_req edge outside HALT is ignored and not queued.
- Reset mid-access: all outputs take reset values asynchronously; a write in progress is aborted and we drops immediately.

## Timing
- Launch at tick edge T. The earliest completion is edge T+WAIT+1, where WAIT is WAIT_CYCLES or 0. Each clk of ext_ready low adds 1.
- we is high for WAIT+1+stall clocks; cyc is high 1 clk.
- The next launch occurs at the first tick at or after the clk following completion.
- Back-to-back fast-region period = max(CLK_DIV, 2) clks when WAIT+1 ≤ CLK_DIV-1. Otherwise the period rounds up to the next tick.
- cpu_rdy rises at most once per launch. The CPU samples cpu_di in the same clk as cpu_rdy, and cpu_di is already valid then.
- HALT exit: a step_req rise is sampled at edge E, giving RUN from E+1. The launch follows at the next tick.

## Test plan
- Reset release, defaults, cpu_ab=16'h0300 read, ext_ready=1, dbi=8'h5A:
  - cyc pulses every 2 clks.
  - ab=0300 one clk after tick.
  - cpu_rdy one clk later with cpu_di=5A.
  - cycle_count increments by 1 per cycle.
- Write cpu_ab=16'hD012, cpu_do=8'h8D, cpu_we=1:
  - ab=D012, dbo=8D.
  - we high exactly 4 clks.
  - cpu_rdy 4 clks after launch.
  - next launch on the following tick.
- ext_ready held low 5 clks in a fast-region read:
  - completion delayed by 5 clks.
  - cyc and cpu_rdy each pulse once.
  - cpu_di captured only when ext_ready=1.
- step_en=1:
  - one cycle completes, then halted=1 and no cyc.
  - a step_req pulse gives exactly one cyc/cpu_rdy, then halted=1 again.
  - step_req held high gives no further steps.
- Reset asserted at wait clk 2 of a slow write: we, cyc, cpu_rdy, ab and cycle_count go to 0 asynchronously; after release, normal operation resumes from RUN.
- CLK_DIV=1 and CLK_DIV=5 builds: fast-region cycle periods are 2 and 5 clks. cycle_count preloaded near 32'hFFFFFFFF wraps to 0.
